add_round_key_seq: RTL
======================

ADD_ROUND_KEY_SEQ -- requirements
Module: add_round_key_seq

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL update only on the rising clock edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 key_load  input  1  single-cycle pulse: capture key_in as cipher key and restart at round 0.
REQ-005 key_in  input  128  cipher key; word k0 = key_in[127:96] ... k3 = key_in[31:0].
REQ-006 in_valid  input  1  w*_curr hold a valid state.
REQ-007 in_ready  output  1  block accepts a state this cycle.
REQ-008 w0_curr, w1_curr, w2_curr, w3_curr  input  32 each  state columns; w0 is the most significant column.
REQ-009 w0_next, w1_next, w2_next, w3_next  output  32 each  state XOR round key, driven to the SubBytes stage.
REQ-010 out_valid  output  1  w*_next valid.
REQ-011 out_ready  input  1  downstream stage accepts the output.
REQ-012 round_out  output  4  index (0..10) of the round key applied to the current output.
REQ-013 last_round  output  1  high when round_out == 10.

Function
REQ-014 The FSM SHALL have two states: NOKEY (no key loaded; in_ready = 0) and RUN; key_load SHALL move any state to RUN.
REQ-015 Key registers: orig_key (the captured key) and rk (the current round key); on key_load, both SHALL take key_in and round SHALL be set to 0.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high; output = {w0..w3}_curr XOR rk, column-wise.
REQ-017 On each input transfer with round < 10, rk SHALL advance: t = SubWord(RotWord(k3)) XOR {Rcon[round+1],24'h0}; k0' = k0^t; k1' = k1^k0'; k2' = k2^k1'; k3' = k3^k2'; round increments by 1.
REQ-018 Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36; SubWord SHALL use four instances of the codebase SBox.
REQ-019 Wrap-around: an input transfer at round 10 SHALL reload rk from orig_key and set round to 0, ready for the next block without a new key_load.
REQ-020 round_out and last_round SHALL reflect the round at which the output's key was applied, not the updated counter.
REQ-021 If key_load and in_valid coincide, key_load SHALL win: in_ready SHALL be 0 that cycle and no transfer SHALL occur.
REQ-022 A pending registered output (see REQ-026) SHALL survive key_load unchanged and drain normally.
REQ-023 Output SHALL stay stable while out_valid = 1 and out_ready = 0.

Reset
REQ-024 On rst: state = NOKEY, round = 0, rk = orig_key = 0, out_valid = 0, w*_next = 0, round_out = 0, last_round = 0, in_ready = 0.
REQ-025 rst SHALL override key_load and any transfer in the same cycle; reset mid-block SHALL discard the pending output and key.

Configuration
REQ-026 With ARK_OUT_REG_EN defined: output is registered; latency is 1 cycle; in_ready = RUN & !key_load & (!out_valid | out_ready); out_valid sets on transfer and clears when out_ready is high and there is no new transfer.
REQ-027 Without ARK_OUT_REG_EN: zero latency; w*_next, round_out and last_round are combinational from w*_curr and rk; out_valid = in_valid & RUN & !key_load; in_ready = out_ready & RUN & !key_load.

Verification
REQ-028 Load key 000102030405060708090a0b0c0d0e0f and send state 00112233445566778899aabbccddeeff -> output 00102030405060708090a0b0c0d0e0f0, round_out = 0.
REQ-029 Same key, send 2 zero states -> second output d6aa74fdd2af72fadaa678f1d6ab76fe, round_out = 1.
REQ-030 Send 11 zero states -> 11th output 13111d7fe3944a17f307a78b4d2b30c5 with last_round = 1; a 12th zero state -> 000102030405060708090a0b0c0d0e0f, round_out = 0 (wrap).
REQ-031 Hold out_ready = 0 for 5 cycles with in_valid = 1 -> the output is held stable, at most one transfer (registered build), and round advances exactly once.
REQ-032 Assert key_load together with in_valid -> no transfer; the next cycle's transfer uses round 0 of the new key.
REQ-033 Assert rst at round 5 -> all outputs are 0, in_ready = 0 until key_load, and no input is accepted.

Source files
------------

// File: rtl/add_round_key_seq.sv
// add_round_key_seq: AES-128 AddRoundKey with on-the-fly key expansion; ARK_OUT_REG_EN selects a registered output stage
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    function automatic logic [7:0] gmul(input logic [7:0] p_a, input logic [7:0] p_b);
        logic [7:0] p, x;
        p = 8'h00;
        x = p_a;
        for (int k = 0; k < 8; k++) begin
            p = p_b[k] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    assign x2   = gmul(a, a);
    assign x3   = gmul(x2, a);
    assign x6   = gmul(x3, x3);
    assign x12  = gmul(x6, x6);
    assign x15  = gmul(x12, x3);
    assign x30  = gmul(x15, x15);
    assign x60  = gmul(x30, x30);
    assign x120 = gmul(x60, x60);
    assign x240 = gmul(x120, x120);
    assign x252 = gmul(x240, x12);
    assign inv  = gmul(x252, x2);
    assign s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module add_round_key_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  w0_curr,
    input  logic [31:0]  w1_curr,
    input  logic [31:0]  w2_curr,
    input  logic [31:0]  w3_curr,
    output logic [31:0]  w0_next,
    output logic [31:0]  w1_next,
    output logic [31:0]  w2_next,
    output logic [31:0]  w3_next,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   round_out,
    output logic         last_round
);
    typedef enum logic {NOKEY, RUN} state_t;

    localparam logic [7:0] RCON [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                         8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    state_t       state;
    logic [127:0] orig_key, rk, res;
    logic [3:0]   round;
    logic [31:0]  rot, sub, t, k0n, k1n, k2n, k3n;
    logic         run, xfer;

    assign rot = {rk[23:0], rk[31:24]};

    genvar i;
    for (i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
    end

    assign t    = sub ^ {RCON[round], 24'h0};
    assign k0n  = rk[127:96] ^ t;
    assign k1n  = rk[95:64] ^ k0n;
    assign k2n  = rk[63:32] ^ k1n;
    assign k3n  = rk[31:0] ^ k2n;
    assign res  = {w0_curr, w1_curr, w2_curr, w3_curr} ^ rk;
    assign run  = (state == RUN) & !key_load & !rst;
    assign xfer = in_valid & in_ready;

    // key capture, round-key advance and wrap back to the original key after round 10
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NOKEY;
            orig_key <= '0;
            rk       <= '0;
            round    <= '0;
        end else if (key_load) begin
            state    <= RUN;
            orig_key <= key_in;
            rk       <= key_in;
            round    <= '0;
        end else if (xfer) begin
            rk    <= (round == 4'd10) ? orig_key : {k0n, k1n, k2n, k3n};
            round <= (round == 4'd10) ? 4'd0 : round + 4'd1;
        end
    end

`ifdef ARK_OUT_REG_EN
    logic [127:0] out_q;

    assign in_ready = run & (!out_valid | out_ready);
    assign {w0_next, w1_next, w2_next, w3_next} = out_q;

    // output register: loads on transfer, holds under backpressure, untouched by key_load
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            round_out  <= '0;
            last_round <= 1'b0;
            out_valid  <= 1'b0;
        end else if (xfer) begin
            out_q      <= res;
            round_out  <= round;
            last_round <= round == 4'd10;
            out_valid  <= 1'b1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
`else
    assign in_ready   = run & out_ready;
    assign out_valid  = run & in_valid;
    assign {w0_next, w1_next, w2_next, w3_next} = res;
    assign round_out  = round;
    assign last_round = round == 4'd10;
`endif
endmodule
